// File: rtl/kmeans_pkg.sv
// Shared definitions for the k-means centroid update block: problem shape and FSM states.
package kmeans_pkg;

  localparam int K = 3;
  localparam int N = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV_D0,
    DIV_D1,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/kmeans_seq_divider.sv
// Restoring unsigned divider: the start cycle performs the first quotient bit, then one bit per cycle,
// so a dividend_width-bit quotient is ready dividend_width cycles after start; busy covers the trailing iterations.
module kmeans_seq_divider #(
  parameter int dividend_width = 17,
  parameter int divisor_width  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [dividend_width-1:0] dividend,
  input  logic [divisor_width-1:0]  divisor,
  output logic                      busy,
  output logic [dividend_width-1:0] quotient
);

  localparam int RW = divisor_width + 1;
  localparam int CW = $clog2(dividend_width + 1);

  logic [RW-1:0]             rem_q;
  logic [dividend_width-1:0] quo_q;
  logic [divisor_width-1:0]  dsr_q;
  logic [CW-1:0]             left_q;

  logic [RW-1:0]                src_rem;
  logic [dividend_width-1:0]    src_quo;
  logic [divisor_width-1:0]     src_dsr;
  logic [RW+dividend_width-1:0] pair_sh;
  logic [RW-1:0]                trial;
  logic                         ge;
  logic [RW-1:0]                rem_nxt;
  logic [dividend_width-1:0]    quo_nxt;

  // Remainder stays below the divisor, so shifting the {rem, quo} pair never loses a set bit.
  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dsr = start ? divisor : dsr_q;
    pair_sh = {src_rem, src_quo} << 1;
    trial   = pair_sh[RW+dividend_width-1:dividend_width];
    ge      = (trial >= {1'b0, src_dsr});
    rem_nxt = ge ? (trial - {1'b0, src_dsr}) : trial;
    quo_nxt = pair_sh[dividend_width-1:0] | dividend_width'(ge);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      left_q <= '0;
    end else if (start || (left_q != '0)) begin
      rem_q  <= rem_nxt;
      quo_q  <= quo_nxt;
      dsr_q  <= src_dsr;
      left_q <= start ? CW'(dividend_width - 1) : left_q - 1'b1;
    end
  end

  assign busy     = (left_q != '0);
  assign quotient = quo_q;

endmodule

// File: rtl/kmeans_centroid_update_k3n2.sv
// Recomputes three 2-D centroids as accumulated sum / point count, one shared serial divider.
// Round-half-up division when KMEANS_DIV_ROUND_EN is defined, floor otherwise; latency is identical.
module kmeans_centroid_update_k3n2
  import kmeans_pkg::*;
#(
  parameter int input_data_width         = 8,
  parameter int input_data_qty_bit_width = 8,
  parameter int acc_width                = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                rd_acc_en,
  output logic [1:0]                          rd_acc_centroid,
  input  logic [acc_width-1:0]                acc0_in,
  input  logic [acc_width-1:0]                acc1_in,
  input  logic [input_data_qty_bit_width-1:0] acc_counter_in,
  input  logic [input_data_width-1:0]         k0d0,
  input  logic [input_data_width-1:0]         k0d1,
  input  logic [input_data_width-1:0]         k1d0,
  input  logic [input_data_width-1:0]         k1d1,
  input  logic [input_data_width-1:0]         k2d0,
  input  logic [input_data_width-1:0]         k2d1,
  output logic [input_data_width-1:0]         new_k0d0,
  output logic [input_data_width-1:0]         new_k0d1,
  output logic [input_data_width-1:0]         new_k1d0,
  output logic [input_data_width-1:0]         new_k1d1,
  output logic [input_data_width-1:0]         new_k2d0,
  output logic [input_data_width-1:0]         new_k2d1,
  output logic                                busy,
  output logic                                done
);

  localparam int DW = acc_width + 1;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_CYC = CW'(acc_width);

  state_t state_q, state_d;
  logic [1:0]                          k_q;
  logic [CW-1:0]                       cyc_q;
  logic [acc_width-1:0]                acc0_q, acc1_q;
  logic [input_data_qty_bit_width-1:0] cnt_q;
  logic [input_data_width-1:0]         q0_q;
  logic [input_data_width-1:0]         new_q [K][N];
  logic [input_data_width-1:0]         cur   [K][N];

  logic                 in_div;
  logic                 div_start;
  logic                 div_busy;
  logic [acc_width-1:0] dim_sum;
  logic [DW-1:0]        dividend;
  logic [DW-1:0]        div_quotient;

  function automatic logic [input_data_width-1:0] sat_q(input logic [DW-1:0] q);
    sat_q = (|q[DW-1:input_data_width]) ? '1 : q[input_data_width-1:0];
  endfunction

  assign cur[0][0] = k0d0;
  assign cur[0][1] = k0d1;
  assign cur[1][0] = k1d0;
  assign cur[1][1] = k1d1;
  assign cur[2][0] = k2d0;
  assign cur[2][1] = k2d1;

  // The divider is idle exactly on the first cycle of each DIV state.
  assign in_div    = (state_q == DIV_D0) || (state_q == DIV_D1);
  assign div_start = in_div && !div_busy;
  assign dim_sum   = (state_q == DIV_D1) ? acc1_q : acc0_q;

`ifdef KMEANS_DIV_ROUND_EN
  assign dividend = {1'b0, dim_sum} + DW'(cnt_q >> 1);
`else
  assign dividend = {1'b0, dim_sum};
`endif

  kmeans_seq_divider #(
    .dividend_width (DW),
    .divisor_width  (input_data_qty_bit_width)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (cnt_q),
    .busy     (div_busy),
    .quotient (div_quotient)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = (acc_counter_in == '0) ? WRITE : DIV_D0;
      DIV_D0:  if (cyc_q == LAST_CYC) state_d = DIV_D1;
      DIV_D1:  if (cyc_q == LAST_CYC) state_d = WRITE;
      WRITE:   state_d = (k_q == 2'(K - 1)) ? DONE : LOAD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      cyc_q   <= '0;
      acc0_q  <= '0;
      acc1_q  <= '0;
      cnt_q   <= '0;
      q0_q    <= '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < N; j++)
          new_q[i][j] <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= (in_div && cyc_q != LAST_CYC) ? cyc_q + 1'b1 : '0;

      if (state_q == LOAD) begin
        acc0_q <= acc0_in;
        acc1_q <= acc1_in;
        cnt_q  <= acc_counter_in;
      end

      // d0 quotient is final while the divider restarts on d1.
      if (state_q == DIV_D1 && !div_busy)
        q0_q <= sat_q(div_quotient);

      if (state_q == WRITE) begin
        for (int i = 0; i < K; i++) begin
          if (k_q == 2'(i)) begin
            if (cnt_q == '0) begin
              new_q[i][0] <= cur[i][0];
              new_q[i][1] <= cur[i][1];
            end else begin
              new_q[i][0] <= q0_q;
              new_q[i][1] <= sat_q(div_quotient);
            end
          end
        end
        if (k_q != 2'(K - 1))
          k_q <= k_q + 1'b1;
      end

      if (state_q == DONE)
        k_q <= '0;
    end
  end

  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign rd_acc_en       = (state_q == LOAD);
  assign rd_acc_centroid = k_q;

  assign new_k0d0 = new_q[0][0];
  assign new_k0d1 = new_q[0][1];
  assign new_k1d0 = new_q[1][0];
  assign new_k1d1 = new_q[1][1];
  assign new_k2d0 = new_q[2][0];
  assign new_k2d1 = new_q[2][1];

endmodule

// File: tb/tb_kmeans_centroid_update_k3n2.sv
// Directed bench for kmeans_centroid_update_k3n2 with a combinational accumulator model.
module tb_kmeans_centroid_update_k3n2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rd_acc_en;
  logic [1:0]  rd_acc_centroid;
  logic [15:0] acc0_in, acc1_in;
  logic [7:0]  acc_counter_in;
  logic [7:0]  k0d0, k0d1, k1d0, k1d1, k2d0, k2d1;
  logic [7:0]  new_k0d0, new_k0d1, new_k1d0, new_k1d1, new_k2d0, new_k2d1;
  logic        busy, done;

  logic [15:0] s0 [3];
  logic [15:0] s1 [3];
  logic [7:0]  cn [3];

  int checks = 0;
  int errors = 0;
  int cyc, rdn, dn;
  logic [7:0] exp_round;

  always #5 clk = ~clk;

  kmeans_centroid_update_k3n2 dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .rd_acc_en       (rd_acc_en),
    .rd_acc_centroid (rd_acc_centroid),
    .acc0_in         (acc0_in),
    .acc1_in         (acc1_in),
    .acc_counter_in  (acc_counter_in),
    .k0d0            (k0d0),
    .k0d1            (k0d1),
    .k1d0            (k1d0),
    .k1d1            (k1d1),
    .k2d0            (k2d0),
    .k2d1            (k2d1),
    .new_k0d0        (new_k0d0),
    .new_k0d1        (new_k0d1),
    .new_k1d0        (new_k1d0),
    .new_k1d1        (new_k1d1),
    .new_k2d0        (new_k2d0),
    .new_k2d1        (new_k2d1),
    .busy            (busy),
    .done            (done)
  );

  always_comb begin
    acc0_in        = '0;
    acc1_in        = '0;
    acc_counter_in = '0;
    if (rd_acc_centroid != 2'd3) begin
      acc0_in        = s0[rd_acc_centroid];
      acc1_in        = s1[rd_acc_centroid];
      acc_counter_in = cn[rd_acc_centroid];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issues start, returns the cycle in which done rose and the number of LOAD cycles seen.
  task automatic run_pass(output int c, output int r);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 1;
    r = 0;
    while (!done && c < 400) begin
      if (rd_acc_en) r++;
      @(posedge clk); #1;
      c++;
    end
    chk("pass_done_seen", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic load_set_a();
    s0[0] = 16'd30;  s1[0] = 16'd40; cn[0] = 8'd10;
    s0[1] = 16'd100; s1[1] = 16'd50; cn[1] = 8'd5;
    s0[2] = 16'd255; s1[2] = 16'd7;  cn[2] = 8'd3;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    k0d0 = 8'd11; k0d1 = 8'd12;
    k1d0 = 8'd7;  k1d1 = 8'd9;
    k2d0 = 8'd13; k2d1 = 8'd14;
    load_set_a();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd_en", {31'd0, rd_acc_en}, 32'd0);
    chk("rst_rd_centroid", {30'd0, rd_acc_centroid}, 32'd0);
    chk("rst_new_k0d0", {24'd0, new_k0d0}, 32'd0);
    chk("rst_new_k2d1", {24'd0, new_k2d1}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // All counts nonzero: full-length pass.
    run_pass(cyc, rdn);
    chk("a_done_cycle", cyc, 32'd109);
    chk("a_rd_cycles", rdn, 32'd3);
    chk("a_k0d0", {24'd0, new_k0d0}, 32'd3);
    chk("a_k0d1", {24'd0, new_k0d1}, 32'd4);
    chk("a_k1d0", {24'd0, new_k1d0}, 32'd20);
    chk("a_k1d1", {24'd0, new_k1d1}, 32'd10);
    chk("a_k2d0", {24'd0, new_k2d0}, 32'd85);
    chk("a_k2d1", {24'd0, new_k2d1}, 32'd2);
    chk("a_busy_after", {31'd0, busy}, 32'd0);

    // Rounding build dependence: 25/10 and 24/10.
`ifdef KMEANS_DIV_ROUND_EN
    exp_round = 8'd3;
`else
    exp_round = 8'd2;
`endif
    s0[0] = 16'd25;
    run_pass(cyc, rdn);
    chk("b_25_div_10", {24'd0, new_k0d0}, {24'd0, exp_round});
    s0[0] = 16'd24;
    run_pass(cyc, rdn);
    chk("b_24_div_10", {24'd0, new_k0d0}, 32'd2);

    // Zero count on k1 keeps the current centroid and skips both divisions.
    s0[0] = 16'd30;
    cn[1] = 8'd0;
    run_pass(cyc, rdn);
    chk("c_done_cycle", cyc, 32'd75);
    chk("c_rd_cycles", rdn, 32'd3);
    chk("c_k1d0", {24'd0, new_k1d0}, 32'd7);
    chk("c_k1d1", {24'd0, new_k1d1}, 32'd9);
    chk("c_k0d0", {24'd0, new_k0d0}, 32'd3);
    chk("c_k2d0", {24'd0, new_k2d0}, 32'd85);

    // Saturation: 65535/255 = 257.
    cn[1] = 8'd5;
    s0[0] = 16'hFFFF;
    s1[0] = 16'd510;
    cn[0] = 8'd255;
    run_pass(cyc, rdn);
    chk("d_sat_k0d0", {24'd0, new_k0d0}, 32'd255);
    chk("d_k0d1", {24'd0, new_k0d1}, 32'd2);
    chk("d_k1d0", {24'd0, new_k1d0}, 32'd20);

    // start held high: the second pass begins only after returning to IDLE.
    load_set_a();
    dn = 0;
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
      if (!busy) break;
    end
    chk("e_done_pulses", dn, 32'd2);
    chk("e_idle_after", {31'd0, busy}, 32'd0);

    // Reset in the middle of DIV_D1 of centroid 0.
    s0[0] = 16'd200;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    chk("f_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("f_rst_busy", {31'd0, busy}, 32'd0);
    chk("f_rst_rd_en", {31'd0, rd_acc_en}, 32'd0);
    chk("f_rst_done", {31'd0, done}, 32'd0);
    chk("f_rst_k0d0", {24'd0, new_k0d0}, 32'd0);
    chk("f_rst_k1d1", {24'd0, new_k1d1}, 32'd0);
    chk("f_rst_k2d0", {24'd0, new_k2d0}, 32'd0);
    rst = 1'b0;
    s0[0] = 16'd30;
    @(posedge clk); #1;
    run_pass(cyc, rdn);
    chk("f_done_cycle", cyc, 32'd109);
    chk("f_k0d0", {24'd0, new_k0d0}, 32'd3);
    chk("f_k0d1", {24'd0, new_k0d1}, 32'd4);
    chk("f_k2d1", {24'd0, new_k2d1}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
